mips_harvard_mem_sequencer: RTL and testbench

//   Shares one single-port synchronous memory between the instruction and data ports
//   of mips_cpu_harvard. Sequences each CPU instruction as fetch -> optional data

---
 rtl/mips_harvard_mem_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_mips_harvard_mem_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_harvard_mem_sequencer.sv
// ---------------------------------------------------------------------------
// mips_harvard_mem_sequencer
//
// Lets a Harvard-interface MIPS core (separate instruction and data ports)
// share one single-port synchronous RAM. Each instruction is run as
//     FETCH -> FWAIT -> DECODE -> [WRITE | DREAD -> DWAIT] -> COMMIT
// and the core is advanced by a single-cycle cpu_clk_enable pulse in COMMIT.
// Between commits the core is frozen. Because the core is frozen, its fetch
// address and its combinational decode of the held instruction stay valid
// for the whole sequence.
//
// Parameters
//   READ_LATENCY  cycles from a mem_read=1 cycle to mem_readdata valid (1..4)
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   cpu_active          core "active" flag; low at COMMIT sends us to HALT
//   cpu_clk_enable      one-cycle pulse per committed instruction
//   cpu_instr_address   core fetch address (byte address)
//   cpu_instr_readdata  held fetched instruction word
//   cpu_data_address    core data address (byte address)
//   cpu_data_read       core load request
//   cpu_data_write      core store request
//   cpu_data_writedata  core store data
//   cpu_data_readdata   held load data
//   mem_address         RAM byte address (0 when no strobe is active)
//   mem_read            RAM read strobe
//   mem_write           RAM write strobe, single cycle
//   mem_writedata       RAM write data (0 when not writing)
//   mem_readdata        RAM read data, READ_LATENCY cycles after mem_read
//   halted              sticky: core committed while cpu_active was low
//   protocol_error      sticky: load and store requested together
//   instr_count         commits since reset, wraps at 2^32
// ---------------------------------------------------------------------------
module mips_harvard_mem_sequencer #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    output logic        cpu_clk_enable,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic        halted,
    output logic        protocol_error,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_WRITE,
        S_DREAD,
        S_DWAIT,
        S_COMMIT,
        S_HALT
    } state_t;

    // The wait counter runs 0 .. READ_LATENCY-1; the data is captured on the
    // cycle the counter reaches its last value, which is exactly the cycle in
    // which the RAM presents the word for the strobe issued before the wait.
    localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [2:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] count_reg, count_next;
    logic        halted_reg, halted_next;
    logic        perr_reg, perr_next;

    // Unqualified strobe/address values produced by the state decode.
    logic        rd_c;
    logic        wr_c;
    logic        clk_en_c;
    logic [31:0] addr_c;
    logic [31:0] wdata_c;

    // -----------------------------------------------------------------------
    // State and held registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 3'd0;
            instr_reg    <= 32'd0;
            data_reg     <= 32'd0;
            count_reg    <= 32'd0;
            halted_reg   <= 1'b0;
            perr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            instr_reg    <= instr_next;
            data_reg     <= data_next;
            count_reg    <= count_next;
            halted_reg   <= halted_next;
            perr_reg     <= perr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and strobe decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        instr_next    = instr_reg;
        data_next     = data_reg;
        count_next    = count_reg;
        halted_next   = halted_reg;
        perr_next     = perr_reg;
        rd_c          = 1'b0;
        wr_c          = 1'b0;
        clk_en_c      = 1'b0;
        addr_c        = 32'd0;
        wdata_c       = 32'd0;

        case (state_reg)
            S_FETCH: begin
                rd_c          = 1'b1;
                addr_c        = cpu_instr_address;
                wait_cnt_next = 3'd0;
                state_next    = S_FWAIT;
            end

            S_FWAIT: begin
                if (wait_cnt_reg == LAST_WAIT) begin
                    instr_next = mem_readdata;
                    state_next = S_DECODE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 3'd1;
                end
            end

            S_DECODE: begin
                // The core decodes instr_reg combinationally; its request
                // lines are only trusted in this state. A store wins over a
                // load, and asking for both is flagged.
                if (cpu_data_write) begin
                    state_next = S_WRITE;
                    if (cpu_data_read) begin
                        perr_next = 1'b1;
                    end
                end else if (cpu_data_read) begin
                    state_next = S_DREAD;
                end else begin
                    state_next = S_COMMIT;
                end
            end

            S_WRITE: begin
                wr_c       = 1'b1;
                addr_c     = cpu_data_address;
                wdata_c    = cpu_data_writedata;
                state_next = S_COMMIT;
            end

            S_DREAD: begin
                rd_c          = 1'b1;
                addr_c        = cpu_data_address;
                wait_cnt_next = 3'd0;
                state_next    = S_DWAIT;
            end

            S_DWAIT: begin
                if (wait_cnt_reg == LAST_WAIT) begin
                    data_next  = mem_readdata;
                    state_next = S_COMMIT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 3'd1;
                end
            end

            S_COMMIT: begin
                clk_en_c   = 1'b1;
                count_next = count_reg + 32'd1;
                if (!cpu_active) begin
                    halted_next = 1'b1;
                    state_next  = S_HALT;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    //
    // Reset is synchronous, so during the reset cycle the state register still
    // holds whatever it had before. Every output is therefore forced to 0
    // while reset is high; this is what stops an in-flight store from reaching
    // the RAM and an in-flight commit from pulsing the core.
    // -----------------------------------------------------------------------
    assign mem_read           = rd_c & ~reset;
    assign mem_write          = wr_c & ~reset;
    assign cpu_clk_enable     = clk_en_c & ~reset;
    assign mem_address        = reset ? 32'd0 : addr_c;
    assign mem_writedata      = reset ? 32'd0 : wdata_c;
    assign cpu_instr_readdata = reset ? 32'd0 : instr_reg;
    assign cpu_data_readdata  = reset ? 32'd0 : data_reg;
    assign instr_count        = reset ? 32'd0 : count_reg;
    assign halted             = halted_reg & ~reset;
    assign protocol_error     = perr_reg & ~reset;

endmodule

// File: tb/tb_mips_harvard_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mips_harvard_mem_sequencer
//
// Two sequencers (READ_LATENCY 1 and 2) each drive their own RAM model and a
// tiny core model. The core model decodes the held instruction word:
//   [31] store   [30] load   (both set = illegal load+store)
//   [27] halt (cpu_active low while this word is held)
//   [15:0] data byte address, store data = {16'h0,[15:0]} ^ 32'h0A00
// A reference model walks each program instruction by instruction, using the
// cycles-per-instruction rules and a word-addressed memory image, and queues
// the expected commits and RAM writes. A monitor pops and compares them as
// the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mips_harvard_mem_sequencer;

    typedef struct {
        logic [31:0] instr;
        int          delta;
        logic [31:0] ldata;
        logic        pe;
        int          cnt;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    // Contents of any RAM word that was never explicitly loaded or stored.
    function automatic logic [31:0] def_word(input int idx);
        return 32'(idx) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_lat
        localparam int L = gi + 1;

        logic        rst = 1'b1;
        logic        cpu_active;
        logic        cpu_clk_enable;
        logic [31:0] cpu_instr_address;
        logic [31:0] cpu_instr_readdata;
        logic [31:0] cpu_data_address;
        logic        cpu_data_read;
        logic        cpu_data_write;
        logic [31:0] cpu_data_writedata;
        logic [31:0] cpu_data_readdata;
        logic [31:0] mem_address;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mem_writedata;
        logic [31:0] mem_readdata;
        logic        halted;
        logic        protocol_error;
        logic [31:0] instr_count;

        mips_harvard_mem_sequencer #(.READ_LATENCY(L)) u_dut (
            .clk                (clk),
            .reset              (rst),
            .cpu_active         (cpu_active),
            .cpu_clk_enable     (cpu_clk_enable),
            .cpu_instr_address  (cpu_instr_address),
            .cpu_instr_readdata (cpu_instr_readdata),
            .cpu_data_address   (cpu_data_address),
            .cpu_data_read      (cpu_data_read),
            .cpu_data_write     (cpu_data_write),
            .cpu_data_writedata (cpu_data_writedata),
            .cpu_data_readdata  (cpu_data_readdata),
            .mem_address        (mem_address),
            .mem_read           (mem_read),
            .mem_write          (mem_write),
            .mem_writedata      (mem_writedata),
            .mem_readdata       (mem_readdata),
            .halted             (halted),
            .protocol_error     (protocol_error),
            .instr_count        (instr_count)
        );

        // ---------------- core model ----------------
        logic [31:0] pc;
        always @(posedge clk) begin
            if (rst)                 pc <= 32'd0;
            else if (cpu_clk_enable) pc <= pc + 32'd4;
        end
        assign cpu_instr_address  = pc;
        assign cpu_data_write     = cpu_instr_readdata[31];
        assign cpu_data_read      = cpu_instr_readdata[30];
        assign cpu_active         = ~cpu_instr_readdata[27];
        assign cpu_data_address   = {16'h0000, cpu_instr_readdata[15:0]};
        assign cpu_data_writedata = {16'h0000, cpu_instr_readdata[15:0]} ^ 32'h0000_0A00;

        // ---------------- RAM model ----------------
        logic [31:0] ram [0:16383];
        bit          vld [0:16383];
        logic [31:0] rd_pipe [0:3];
        logic        ld_en   = 1'b0;
        logic        ld_clr  = 1'b0;
        logic [31:0] ld_addr = 32'd0;
        logic [31:0] ld_data = 32'd0;

        function automatic logic [31:0] ram_rd(input logic [31:0] a);
            int idx;
            idx = int'(a[15:2]);
            return vld[idx] ? ram[idx] : def_word(idx);
        endfunction

        always @(posedge clk) begin
            if (ld_clr) begin
                for (int k = 0; k < 16384; k++) vld[k] <= 1'b0;
            end else if (ld_en) begin
                ram[int'(ld_addr[15:2])] <= ld_data;
                vld[int'(ld_addr[15:2])] <= 1'b1;
            end else if (mem_write) begin
                ram[int'(mem_address[15:2])] <= mem_writedata;
                vld[int'(mem_address[15:2])] <= 1'b1;
            end
            rd_pipe[0] <= mem_read ? ram_rd(mem_address) : 32'hDEAD_BEEF;
            for (int k = 1; k < 4; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mem_readdata = rd_pipe[L-1];

        // ---------------- reference model ----------------
        logic [31:0] refm [int];
        exp_t        exp_q [$];
        wr_t         wr_q [$];
        int          n_prog;

        function automatic logic [31:0] ref_rd(input logic [31:0] a);
            int idx;
            idx = int'(a[15:2]);
            return refm.exists(idx) ? refm[idx] : def_word(idx);
        endfunction

        task automatic build_ref();
            logic [31:0] p, w, a, ld, sd;
            logic        pe;
            int          d;
            p  = 32'd0;
            ld = 32'd0;
            pe = 1'b0;
            n_prog = 0;
            exp_q.delete();
            wr_q.delete();
            for (int i = 0; i < 200; i++) begin
                w  = ref_rd(p);
                a  = {16'h0000, w[15:0]};
                sd = a ^ 32'h0000_0A00;
                if (w[31]) begin
                    d = 4 + L;
                    refm[int'(a[15:2])] = sd;
                    wr_q.push_back('{addr: a, data: sd});
                    if (w[30]) pe = 1'b1;
                end else if (w[30]) begin
                    d  = 4 + 2 * L;
                    ld = ref_rd(a);
                end else begin
                    d = 3 + L;
                end
                n_prog++;
                exp_q.push_back('{instr: w, delta: d, ldata: ld, pe: pe, cnt: n_prog});
                if (w[27]) break;
                p = p + 32'd4;
            end
        endtask

        // ---------------- monitor ----------------
        logic mon_en = 1'b0;
        int   cyc    = 0;
        int   prev   = -1;
        exp_t mon_e;
        wr_t  mon_w;

        always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

        always @(negedge clk) begin
            if (rst) begin
                prev = -1;
            end else if (mon_en) begin
                check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
                if (!mem_read && !mem_write) check("idle_addr", mem_address, 32'd0);
                if (mem_write) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 32'(mem_write), 32'd0);
                    end else begin
                        mon_w = wr_q.pop_front();
                        check("wr_addr", mem_address, mon_w.addr);
                        check("wr_data", mem_writedata, mon_w.data);
                    end
                end
                if (cpu_clk_enable) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_commit", 32'(cpu_clk_enable), 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        $display("L=%0d commit %0d: instr=%h ldata=%h cycles=%0d count=%0d",
                                 L, mon_e.cnt, cpu_instr_readdata, cpu_data_readdata,
                                 cyc - prev, instr_count);
                        check("cpi", 32'(cyc - prev), 32'(mon_e.delta));
                        check("commit_instr", cpu_instr_readdata, mon_e.instr);
                        check("commit_ldata", cpu_data_readdata, mon_e.ldata);
                        check("commit_perr", 32'(protocol_error), 32'(mon_e.pe));
                        check("commit_count", instr_count, 32'(mon_e.cnt - 1));
                        check("commit_halted", 32'(halted), 32'd0);
                    end
                    prev = cyc;
                end
            end
        end

        // ---------------- stimulus ----------------
        task automatic begin_load();
            mon_en = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
            ld_clr = 1'b1;
            @(posedge clk);
            #1 ld_clr = 1'b0;
            refm.delete();
        endtask

        task automatic put(input logic [31:0] a, input logic [31:0] d);
            refm[int'(a[15:2])] = d;
            ld_en   = 1'b1;
            ld_addr = a;
            ld_data = d;
            @(posedge clk);
            #1 ld_en = 1'b0;
        endtask

        task automatic run_prog(input string tag);
            int i;
            build_ref();
            @(negedge clk);
            check({tag, "_rst_strobes"},
                  {27'd0, mem_read, mem_write, cpu_clk_enable, halted, protocol_error}, 32'd0);
            check({tag, "_rst_bus"}, mem_address | mem_writedata, 32'd0);
            check({tag, "_rst_held"}, cpu_instr_readdata | cpu_data_readdata, 32'd0);
            check({tag, "_rst_count"}, instr_count, 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            mon_en = 1'b1;
            @(negedge clk);
            check({tag, "_c1_read"}, 32'(mem_read), 32'd1);
            check({tag, "_c1_addr"}, mem_address, 32'd0);
            check({tag, "_c1_other"}, {29'd0, mem_write, cpu_clk_enable, halted}, 32'd0);
            check({tag, "_c1_count"}, instr_count, 32'd0);
            i = 0;
            while (!halted && i < 4000) begin
                @(negedge clk);
                i++;
            end
            check({tag, "_halt_reached"}, 32'(halted), 32'd1);
            check({tag, "_commits_left"}, 32'(exp_q.size()), 32'd0);
            check({tag, "_writes_left"}, 32'(wr_q.size()), 32'd0);
            check({tag, "_final_count"}, instr_count, 32'(n_prog));
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                check({tag, "_halt_quiet"}, {29'd0, mem_read, mem_write, cpu_clk_enable}, 32'd0);
                check({tag, "_halt_sticky"}, 32'(halted), 32'd1);
            end
            mon_en = 1'b0;
        endtask

        // Launch one instruction, then assert reset on cycle 1+hold.
        task automatic reset_abort(input logic [31:0] word, input int hold, input string tag);
            begin_load();
            put(32'd0, word);
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (hold) @(posedge clk);
            #1 rst = 1'b1;
            @(negedge clk);
            check({tag, "_no_write"}, 32'(mem_write), 32'd0);
            check({tag, "_no_commit"}, 32'(cpu_clk_enable), 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check({tag, "_count"}, instr_count, 32'd0);
            check({tag, "_refetch"}, 32'(mem_read), 32'd1);
            check({tag, "_ldata"}, cpu_data_readdata, 32'd0);
            check({tag, "_ram_untouched"}, 32'(vld[int'(word[15:2])]), 32'd0);
        endtask

        initial begin
            logic [31:0] w;

            // Directed: ALU, store 0xAA00, load 0xAA0A, load-back, load+store, halt.
            begin_load();
            put(32'h0000_0000, 32'h2402_2000);
            put(32'h0000_0004, 32'h8000_AA00);
            put(32'h0000_0008, 32'h4000_AA0A);
            put(32'h0000_000C, 32'h4000_AA00);
            put(32'h0000_0010, 32'hC000_B004);
            put(32'h0000_0014, 32'h0800_0000);
            put(32'h0000_AA08, 32'hCC00_0000);
            run_prog("dir");

            // Random programs ending in a halt word.
            for (int r = 0; r < 2; r++) begin
                begin_load();
                for (int i = 0; i < 24; i++) begin
                    w     = $urandom;
                    w[27] = 1'b0;
                    w[15] = 1'b1;
                    put(32'(4 * i), w);
                end
                w     = $urandom;
                w[27] = 1'b1;
                w[15] = 1'b1;
                put(32'(4 * 24), w);
                run_prog("rnd");
            end

            reset_abort(32'h8000_8010, 2 + L, "rst_in_write");
            reset_abort(32'h4000_8020, 3 + L, "rst_in_dwait");
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && n_done < 2; i++) @(posedge clk);
        if (n_done < 2) check("global_timeout", 32'(n_done), 32'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
